// File: rtl/credit_out_buffer_pkg.sv
// Shared configuration for the credit-based datapath blocks.
//   PATH_WIDTH      : default datapath width of words moving between stages
//   DEFAULT_CREDITS : default number of downstream credits a stage starts with
package credit_out_buffer_pkg;

  localparam int PATH_WIDTH      = 64;
  localparam int DEFAULT_CREDITS = 2;

endpackage

// File: rtl/credit_out_buffer_credit_counter.sv
// credit_counter: saturating up/down credit counter that starts at CREDITS.
// Ports:
//   clk          in  clock, rising edge
//   rst          in  asynchronous active-low reset, reloads CREDITS
//   inc          in  one credit returned by the consumer
//   dec          in  one credit spent (caller only asserts it while nonzero)
//   nonzero      out at least one credit available
//   overflow_err out inc arrived while already at CREDITS with no dec
module credit_counter
  import credit_out_buffer_pkg::*;
#(
  parameter int CREDITS = DEFAULT_CREDITS,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic overflow_err
);

  localparam logic [CW-1:0] MAX_CRED = CW'(CREDITS);

  logic [CW-1:0] credits;

  // inc and dec together cancel out; inc alone saturates at MAX_CRED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits <= MAX_CRED;
    end else if (inc && !dec && credits != MAX_CRED) begin
      credits <= credits + CW'(1);
    end else if (dec && !inc) begin
      credits <= credits - CW'(1);
    end
  end

  assign nonzero      = (credits != '0);
  assign overflow_err = inc && !dec && (credits == MAX_CRED);

endmodule

// File: rtl/credit_out_buffer.sv
// credit_out_buffer: small FIFO sitting behind a credit-driven producer.
// Captures upstream words, returns one upstream credit per drained entry, and
// forwards entries downstream under its own credit counter, gated by done.
// Ports:
//   clk        in  clock, rising edge
//   rst        in  asynchronous active-low reset
//   valid_in   in  upstream word valid
//   data_in    in  upstream word
//   credit_in  in  one-cycle pulse, credit returned by downstream
//   done       in  configuration complete; output side stalls while low
//   credit_out out one-cycle pulse, credit returned upstream
//   data_out   out registered output word (holds when idle)
//   valid_out  out registered output valid
//   err        out sticky protocol violation (overflow write or credit overflow)
module credit_out_buffer
  import credit_out_buffer_pkg::*;
#(
  parameter int WIDTH   = PATH_WIDTH,
  parameter int DEPTH   = 4,
  parameter int CREDITS = DEFAULT_CREDITS,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             credit_in,
  input  logic             done,
  output logic             credit_out,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [NW-1:0]    count;

  logic credit_nz;
  logic credit_ovf;
  logic full;
  logic pop;
  logic accept;
  logic drop;

  credit_counter #(
    .CREDITS (CREDITS),
    .CW      (CW)
  ) u_credits (
    .clk          (clk),
    .rst          (rst),
    .inc          (credit_in),
    .dec          (pop),
    .nonzero      (credit_nz),
    .overflow_err (credit_ovf)
  );

  // pop looks at the registered credit count, so a credit arriving in the
  // same cycle only enables the pop on the following edge.
  assign full   = (count == FULL_CNT);
  assign pop    = done && (count != '0) && credit_nz;
  // A pop in the same cycle frees the head slot, so a full FIFO can still
  // accept.
  assign accept = valid_in && (!full || pop);
  assign drop   = valid_in && full && !pop;

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out  <= 1'b0;
      credit_out <= 1'b0;
      data_out   <= '0;
      err        <= 1'b0;
    end else begin
      valid_out  <= pop;
      credit_out <= pop;
      if (pop) data_out <= mem[rd_ptr];
      err <= err | drop | credit_ovf;
    end
  end

endmodule

// File: doc/credit_out_buffer.md
Name: credit_out_buffer

Overview:
- Downstream neighbour of ff_stage: captures ff_stage's valid_out/data_out into a small FIFO and returns one credit per drained entry on credit_out, which feeds ff_stage's credit_in.
- Forwards buffered data to the next consumer (switch/output port) under its own credit counter, gated by the global configuration-done signal.
- Decouples ff_stage from downstream stalls.

Parameters:
- WIDTH, `PATH_WIDTH (64), datapath width.
- DEPTH, 4, FIFO entries; power of two, >= 2. This is also the upstream's initial credit count.
- CREDITS, 2, initial/maximum downstream credits; >= 1.
- CW, $clog2(CREDITS+1), credit counter width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- valid_in  in  1  upstream data valid (from ff_stage valid_out).
- data_in  in  WIDTH  upstream data.
- credit_in  in  1  one-cycle pulse, one credit returned by downstream.
- done  in  1  configuration complete; when 0, output side stalls.
- credit_out  out  1  one-cycle pulse, one credit returned upstream.
- data_out  out  WIDTH  registered output data.
- valid_out  out  1  registered output valid.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, pointers 0, count 0, credits=CREDITS. valid_out=0, credit_out=0, data_out=0, err=0. Reset mid-stream discards all entries without returning credits.
- accept = valid_in && (count<DEPTH || pop): write data_in at wr_ptr, wr_ptr+1 mod DEPTH.
- valid_in while full with no pop: data dropped, err<=1.
- Write is independent of done; the input side is governed only by the upstream credit protocol.
- pop = done && count>0 && credits>0: dequeue the head entry and register it:
  - data_out<=head, valid_out<=1, credit_out<=1;
  - rd_ptr+1 mod DEPTH.
- No pop: valid_out<=0, credit_out<=0, data_out holds its last value.
- count next = count + accept - pop.
- Credits next = credits - pop + credit_in, saturating at CREDITS. credit_in at CREDITS with no pop sets err<=1 and credits stay at CREDITS.
- Latency: valid_in sampled at edge N into an empty FIFO (done=1, credits>0) gives valid_out/data_out/credit_out high after edge N+1. Back-to-back throughput is 1 word/cycle while credits last.
- Empty FIFO: no pop, valid_out=0.
- Zero credits: entries held; the pop resumes on the cycle after credit_in is sampled.
- Simultaneous credit_in and pop at credits==0: no pop that cycle (pop uses the registered count); credits become 1.
- done falling mid-stream: pops stop on the next edge and contents are retained. Pops resume in FIFO order when done returns.
- FIFO order is strict; pointers wrap at DEPTH.
- err clears only on reset.

Decomposition:
- config.v (shared include) holds `PATH_WIDTH and `DEFAULT_CREDITS. No new typedefs.
- One sub-module, credit_counter:
  - saturating up/down counter with init value CREDITS;
  - inputs inc, dec; outputs nonzero, overflow_err.
  - Reused by ff_stage-class blocks.
- FIFO storage and pointers stay inline.

Test Plan:
- Reset: rst=0 with credit_in/valid_in toggling -> valid_out=0, credit_out=0, data_out=0, err=0. After release, a single word 0xA5 gives valid_out=1, data_out=0xA5, credit_out=1 exactly one cycle after capture.
- Credit stall:
  - Send 3 words (0x1,0x2,0x3), CREDITS=2, no credit_in -> only 0x1,0x2 emitted, 0x3 held.
  - Pulse credit_in once -> 0x3 emitted the next cycle.
  - 3 credit_out pulses total.
- Full plus simultaneous pop:
  - Fill 4 entries with done=0, then raise done.
  - Present valid_in on the pop cycle -> write accepted, err stays 0.
  - Without the pop -> err=1 and the word is dropped.
- done gating: done=0 after 1 of 3 words emitted -> output stops. Restoring done -> remaining words emitted in order, no loss or duplication.
- Credit overflow: credit_in pulsed at credits==CREDITS -> err=1, and only CREDITS further words flow without new credits.
- Reset mid-stream: rst=0 with 2 entries queued -> outputs 0 immediately (asynchronously). After release, FIFO is empty and credits=CREDITS.
